// File: rtl/debounce_pkg.sv
// Shared types and constants for the time-shared button debounce controller.
package debounce_pkg;

   // Controller states; encoding is fixed at IDLE=0, WAIT=1, COMMIT=2.
   typedef enum logic [1:0] {
      StIdle   = 2'd0,
      StWait   = 2'd1,
      StCommit = 2'd2
   } state_e;

   // Terminal count of the shared wait counter, about 400 us at 12 MHz.
   localparam int unsigned DefaultMaxClkCount = 4799;

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin picker: searches req starting just after last_grant.
module rr_pick #(
   parameter int unsigned NUM_BTNS = 4
) (
   input  logic [NUM_BTNS-1:0]         req,
   input  logic [$clog2(NUM_BTNS)-1:0] last_grant,
   output logic                        any_req,
   output logic [$clog2(NUM_BTNS)-1:0] winner
);

   localparam int unsigned GW = $clog2(NUM_BTNS);

   int unsigned      idx;
   logic [GW-1:0]    cand;

   // First requester found walking upward (with wrap) from last_grant+1 wins.
   always_comb begin
      any_req = 1'b0;
      winner  = '0;
      idx     = 0;
      cand    = '0;
      for (int unsigned k = 1; k <= NUM_BTNS; k++) begin
         idx  = (32'(last_grant) + k) % NUM_BTNS;
         cand = GW'(idx);
         if (!any_req && req[cand]) begin
            any_req = 1'b1;
            winner  = cand;
         end
      end
   end

endmodule

// File: rtl/debounce_scheduler.sv
// Debounces NUM_BTNS active-low buttons using a single wait counter that is
// handed to one changed button at a time in round-robin order.
module debounce_scheduler
   import debounce_pkg::*;
#(
   parameter int unsigned NUM_BTNS      = 4,
   parameter int unsigned MAX_CLK_COUNT = DefaultMaxClkCount
) (
   input  logic                        clk,
   input  logic                        rst,
   input  logic [NUM_BTNS-1:0]         btn_in,
   output logic [NUM_BTNS-1:0]         db_level,
   output logic [NUM_BTNS-1:0]         press_pulse,
   output logic [NUM_BTNS-1:0]         release_pulse,
   output logic                        busy,
   output logic [$clog2(NUM_BTNS)-1:0] grant_idx
);

   localparam int unsigned   GW     = $clog2(NUM_BTNS);
   localparam int unsigned   CW     = $clog2(MAX_CLK_COUNT + 1);
   localparam logic [CW-1:0] CntMax = CW'(MAX_CLK_COUNT);

   logic [NUM_BTNS-1:0] pressed;
   logic [NUM_BTNS-1:0] req;
   logic                any_req;
   logic [GW-1:0]       winner;

   state_e              state_q, state_d;
   logic [CW-1:0]       cnt_q, cnt_d;
   logic [GW-1:0]       grant_q, grant_d;
   logic [GW-1:0]       last_q, last_d;
   logic [NUM_BTNS-1:0] db_q, db_d;
   logic [NUM_BTNS-1:0] press_q, press_d;
   logic [NUM_BTNS-1:0] rel_q, rel_d;

   for (genvar i = 0; i < NUM_BTNS; i++) begin : g_sync
      logic s1_q, s2_q;
      // Two-flop synchronizer; idle (released) level is 1.
      always_ff @(posedge clk or posedge rst) begin
         if (rst) begin
            s1_q <= 1'b1;
            s2_q <= 1'b1;
         end else begin
            s1_q <= btn_in[i];
            s2_q <= s1_q;
         end
      end
      assign pressed[i] = ~s2_q;
   end

   // A button wants the counter whenever its live level disagrees with the debounced one.
   assign req = pressed ^ db_q;

   rr_pick #(
      .NUM_BTNS(NUM_BTNS)
   ) u_pick (
      .req       (req),
      .last_grant(last_q),
      .any_req   (any_req),
      .winner    (winner)
   );

   // Next-state logic: grant, wait for stability or abort on bounce, then commit.
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      grant_d = grant_q;
      last_d  = last_q;
      db_d    = db_q;
      press_d = press_q;
      rel_d   = rel_q;
      case (state_q)
         StIdle: begin
            if (any_req) begin
               grant_d = winner;
               cnt_d   = '0;
               state_d = StWait;
            end
         end
         StWait: begin
            if (pressed[grant_q] == db_q[grant_q]) begin
               // Bounced back: give up the counter and move the pointer past this button.
               last_d  = grant_q;
               state_d = StIdle;
            end else if (cnt_q == CntMax) begin
               db_d[grant_q] = ~db_q[grant_q];
               if (!db_q[grant_q]) begin
                  press_d[grant_q] = 1'b1;
               end else begin
                  rel_d[grant_q] = 1'b1;
               end
               state_d = StCommit;
            end else begin
               cnt_d = cnt_q + CW'(1);
            end
         end
         StCommit: begin
            last_d  = grant_q;
            press_d = '0;
            rel_d   = '0;
            state_d = StIdle;
         end
         default: begin
            state_d = StIdle;
         end
      endcase
   end

   // State and datapath registers.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= StIdle;
         cnt_q   <= '0;
         grant_q <= '0;
         last_q  <= GW'(NUM_BTNS - 1);
         db_q    <= '0;
         press_q <= '0;
         rel_q   <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         grant_q <= grant_d;
         last_q  <= last_d;
         db_q    <= db_d;
         press_q <= press_d;
         rel_q   <= rel_d;
      end
   end

   assign db_level      = db_q;
   assign press_pulse   = press_q;
   assign release_pulse = rel_q;
   assign busy          = (state_q != StIdle);
   assign grant_idx     = grant_q;

endmodule

// File: tb/tb_debounce_scheduler.sv
// Directed bench for debounce_scheduler with NUM_BTNS=4, MAX_CLK_COUNT=7.
module tb_debounce_scheduler;

   logic       clk = 1'b0;
   logic       rst;
   logic [3:0] btn_in;
   logic [3:0] db_level;
   logic [3:0] press_pulse;
   logic [3:0] release_pulse;
   logic       busy;
   logic [1:0] grant_idx;

   int checks   = 0;
   int failures = 0;
   int seen     = 0;

   always #5 clk = ~clk;

   debounce_scheduler #(
      .NUM_BTNS     (4),
      .MAX_CLK_COUNT(7)
   ) dut (
      .clk          (clk),
      .rst          (rst),
      .btn_in       (btn_in),
      .db_level     (db_level),
      .press_pulse  (press_pulse),
      .release_pulse(release_pulse),
      .busy         (busy),
      .grant_idx    (grant_idx)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic quiet(input string tag);
      chk({tag, "_press"}, 32'(press_pulse), 32'd0);
      chk({tag, "_release"}, 32'(release_pulse), 32'd0);
   endtask

   // n quiet edges, then the commit edge, then one more edge back to IDLE.
   task automatic wait_pulse(input string tag, input int n, input logic [3:0] ep,
                             input logic [3:0] er, input logic [3:0] edb, input logic [1:0] eg);
      for (int i = 0; i < n; i++) begin
         tick();
         quiet({tag, "_pre"});
      end
      tick();
      chk({tag, "_press"}, 32'(press_pulse), 32'(ep));
      chk({tag, "_release"}, 32'(release_pulse), 32'(er));
      chk({tag, "_db"}, 32'(db_level), 32'(edb));
      chk({tag, "_grant"}, 32'(grant_idx), 32'(eg));
      chk({tag, "_busy"}, 32'(busy), 32'd1);
      tick();
      quiet({tag, "_post"});
      chk({tag, "_post_busy"}, 32'(busy), 32'd0);
   endtask

   initial begin
      // Reset
      rst    = 1'b1;
      btn_in = 4'hF;
      tick();
      tick();
      chk("rst_db", 32'(db_level), 32'd0);
      quiet("rst");
      chk("rst_busy", 32'(busy), 32'd0);
      chk("rst_grant", 32'(grant_idx), 32'd0);
      rst = 1'b0;
      for (int i = 0; i < 20; i++) begin
         tick();
         quiet("idle");
         chk("idle_busy", 32'(busy), 32'd0);
      end

      // Clean press and release of button 0
      btn_in = 4'b1110;
      wait_pulse("clean_press", 10, 4'b0001, 4'b0000, 4'b0001, 2'd0);
      tick();
      tick();
      btn_in = 4'b1111;
      wait_pulse("clean_rel", 10, 4'b0000, 4'b0001, 4'b0000, 2'd0);

      // Bouncy press of button 1: low, high, low, high, then final low
      for (int t = 0; t < 4; t++) begin
         btn_in[1] = ~btn_in[1];
         for (int i = 0; i < 3; i++) begin
            tick();
            quiet("bounce");
            chk("bounce_db", 32'(db_level), 32'd0);
         end
      end
      btn_in[1] = 1'b0;
      wait_pulse("bounce_press", 10, 4'b0010, 4'b0000, 4'b0010, 2'd1);
      btn_in = 4'b1111;
      wait_pulse("bounce_rel", 10, 4'b0000, 4'b0010, 4'b0000, 2'd1);

      // Simultaneous press of buttons 0 and 2 right after reset
      rst = 1'b1;
      tick();
      rst = 1'b0;
      tick();
      btn_in = 4'b1010;
      wait_pulse("sim_p0", 10, 4'b0001, 4'b0000, 4'b0001, 2'd0);
      wait_pulse("sim_p2", 8, 4'b0100, 4'b0000, 4'b0101, 2'd2);
      btn_in = 4'b1111;
      wait_pulse("sim_r0", 10, 4'b0000, 4'b0001, 4'b0100, 2'd0);
      wait_pulse("sim_r2", 8, 4'b0000, 4'b0100, 4'b0000, 2'd2);

      // Fairness: button 3 bounces every 2 cycles, button 1 held low
      btn_in = 4'b0101;
      seen   = 0;
      for (int i = 0; i < 30; i++) begin
         tick();
         if (i % 2 == 1) btn_in[3] = ~btn_in[3];
         chk("fair_p3", 32'(press_pulse[3]), 32'd0);
         chk("fair_r3", 32'(release_pulse[3]), 32'd0);
         chk("fair_db3", 32'(db_level[3]), 32'd0);
         if (press_pulse[1]) seen++;
      end
      chk("fair_p1_count", 32'(seen), 32'd1);
      chk("fair_db1", 32'(db_level[1]), 32'd1);

      // Reset mid-WAIT, then recovery with the button still held
      rst    = 1'b1;
      btn_in = 4'hF;
      tick();
      chk("rst2_db", 32'(db_level), 32'd0);
      quiet("rst2");
      rst = 1'b0;
      tick();
      tick();
      btn_in = 4'b1110;
      for (int i = 0; i < 6; i++) begin
         tick();
         quiet("mid_pre");
      end
      chk("mid_busy", 32'(busy), 32'd1);
      chk("mid_grant", 32'(grant_idx), 32'd0);
      rst = 1'b1;
      #1;
      chk("mid_rst_busy", 32'(busy), 32'd0);
      chk("mid_rst_db", 32'(db_level), 32'd0);
      quiet("mid_rst");
      tick();
      tick();
      quiet("mid_hold");
      rst = 1'b0;
      wait_pulse("mid_recover", 10, 4'b0001, 4'b0000, 4'b0001, 2'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/debounce_scheduler.md
# debounce_scheduler

Time-shared debounce controller for multiple push buttons. One wait counter is shared among `NUM_BTNS` raw, active-low button inputs and granted to one changed button at a time in round-robin order. The block produces clean debounced levels plus single-cycle press and release strobes. It sits between board button pins and downstream counter/LED logic, and replaces per-button debounce counters.

## Interface
- `NUM_BTNS`, default 4: number of buttons (legal range 2..8).
- `MAX_CLK_COUNT`, default 4799: terminal count of the shared wait counter; 4799 gives about 400 us at 12 MHz; must be at least 1.
- `clk` input, 1 bit: system clock.
- `rst` input, 1 bit: asynchronous, active-high reset.
- `btn_in` input, `NUM_BTNS` bits: raw buttons, active low, asynchronous to `clk`.
- `db_level` output, `NUM_BTNS` bits: debounced state, 1 = pressed.
- `press_pulse` output, `NUM_BTNS` bits: one-cycle strobe on a committed press.
- `release_pulse` output, `NUM_BTNS` bits: one-cycle strobe on a committed release.
- `busy` output, 1 bit: high whenever the FSM is not in IDLE.
- `grant_idx` output, `$clog2(NUM_BTNS)` bits: button currently owning the counter; valid only while `busy` is high.

## Operation
- **Input conditioning.** Each `btn_in` bit passes through a 2-FF synchronizer (sync flops reset to 1). `pressed[i]` is the inverted synchronizer output.
- **Request.** `req[i] = pressed[i] != db_level[i]`.
- **Arbitration pointer.** `last_grant` resets to `NUM_BTNS-1`, so button 0 has first priority after reset. The search starts at `(last_grant+1) mod NUM_BTNS`.
- **FSM states and transitions:**
  - IDLE: if any `req` is set, latch the winner into `grant_idx`, clear the counter, and go to WAIT. Otherwise stay.
  - WAIT, abort case: if `pressed[g] == db_level[g]` (bounce back), set `last_grant <= g` and go to IDLE. No pulse.
  - WAIT, terminal case: else if `counter == MAX_CLK_COUNT`, go to COMMIT, toggle `db_level[g]`, and raise `press_pulse[g]` (new level 1) or `release_pulse[g]` (new level 0).
  - WAIT, otherwise: increment the counter.
  - COMMIT: set `last_grant <= g`, clear the pulses, and go to IDLE unconditionally.
- **Pulses.** At most one pulse bit is high in any cycle; each pulse is high only for the single COMMIT cycle.
- **Counter width.** `$clog2(MAX_CLK_COUNT+1)` bits. The counter never wraps, because it is compared against `MAX_CLK_COUNT` before incrementing.
- **Requests during a grant.** Requests from non-granted buttons are held implicitly by level comparison and are never lost. A button that changes and reverts while waiting for a grant simply drops its request.
- **Reset values.** All outputs are 0, the state is IDLE, the counter is 0, and `last_grant` is `NUM_BTNS-1`.
- **Reset mid-operation.** Reset during WAIT or COMMIT abandons the grant immediately and produces no pulse.

## Timing
- **Latency, single request.** The raw edge is captured at edge 0; `pressed` is valid after edge 1. IDLE→WAIT occurs at edge 2. WAIT lasts `MAX_CLK_COUNT+1` cycles, so COMMIT (pulse high, `db_level` updated) occurs at edge `MAX_CLK_COUNT+3`.
- **Back-to-back grants.** COMMIT→IDLE takes 1 cycle and IDLE→WAIT takes 1 cycle. The next grant's COMMIT therefore lands `MAX_CLK_COUNT+3` cycles after the previous COMMIT.
- **Abort timing.** An abort takes effect at the first cycle in which the bounce is visible on `pressed`. The bounced button re-enters arbitration behind all other requesters.
- **Signal timing.**
  - `busy` is registered and derived from the state.
  - `grant_idx` changes only on the IDLE→WAIT transition.

## Structure
- **Package `debounce_pkg`:**
  - State encoding constants IDLE=0, WAIT=1, COMMIT=2 (2-bit).
  - Default `MAX_CLK_COUNT` constant 4799.
- **Sub-module `rr_pick`:** a combinational round-robin priority picker. Inputs are `req` and `last_grant`; outputs are `any_req` and `winner`. It is instantiated once.
- **Synchronizers.** Inline generate loop in the top module; no separate module.

## Test plan
All scenarios use `NUM_BTNS=4` and `MAX_CLK_COUNT=7`.
- **Reset:** assert `rst` with `btn_in=4'hF` → all outputs 0, `busy` 0. Then drive `btn_in=4'hF` for 20 cycles → no pulses.
- **Clean press:** `btn_in[0]` goes 1→0 at edge 0 and is held → `press_pulse=4'b0001` exactly at edge 10 for one cycle, `db_level=4'b0001`. Release later → `release_pulse[0]` 10 cycles after the edge, `db_level=0`.
- **Bouncy press:** toggle `btn_in[1]` every 3 cycles, 5 times, ending low → each revert aborts WAIT. Exactly one `press_pulse[1]`, 10 cycles after the final edge.
- **Simultaneous press:** `btn_in[0]` and `btn_in[2]` go low together after reset → `press_pulse[0]` at edge 10 and `press_pulse[2]` at edge 20; `grant_idx` reads 0, then 2.
- **Fairness:** `btn_in[3]` bounces every 2 cycles indefinitely while `btn_in[1]` is held low → `press_pulse[1]` fires within 2 grant periods (≤ 30 cycles) and `db_level[3]` never changes.
- **Reset mid-WAIT:** press `btn_in[0]` and assert `rst` at edge 6 → no pulse, `db_level=0`. Deassert `rst` with the button still held → `press_pulse[0]` 10 cycles after deassertion.
